axi_burst_master: RTL

- Parametrised AXI4 master that bridges a CPU- or cache-side request interface onto one AXI master port.
- Successor to the fixed single-beat memory-port master. Adds:
  - INCR bursts of 1..MAX_LEN beats.
  - Valid/ready streams for read data and write data.
  - Error reporting, with request rejection for illegal lengths and 4KB-crossing requests.
  - Configurable data width and ID.
- Intended for instruction-cache refill and for DMA/data-cache write-back masters.

---
 rtl/axi_burst_master_if.sv | 76 +++++++
 rtl/axi_burst_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// Request, stream and AXI4 master bus bundle for axi_burst_master.
// The req_wrap member exists only when AXI_MASTER_WRAP_BURST_EN is defined.
interface axi_burst_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    // Every channel transfers on the cycle where its valid and ready are both
    // high; a raised valid stays high with stable payload until that cycle.
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [STRB_W-1:0] req_strb;
`ifdef AXI_MASTER_WRAP_BURST_EN
    logic              req_wrap;
`endif
    logic [DATA_W-1:0] wd_data;
    logic              wd_valid, wd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_last, rd_ready;
    logic              resp_valid, resp_err, busy;

    logic [ID_W-1:0]   ARID_M, RID_M, AWID_M, BID_M;
    logic [ADDR_W-1:0] ARADDR_M, AWADDR_M;
    logic [3:0]        ARLEN_M, AWLEN_M;
    logic [2:0]        ARSIZE_M, AWSIZE_M;
    logic [1:0]        ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
    logic              ARVALID_M, ARREADY_M, AWVALID_M, AWREADY_M;
    logic [DATA_W-1:0] RDATA_M, WDATA_M;
    logic              RLAST_M, RVALID_M, RREADY_M;
    logic [STRB_W-1:0] WSTRB_M;
    logic              WLAST_M, WVALID_M, WREADY_M;
    logic              BVALID_M, BREADY_M;

    modport master (
`ifdef AXI_MASTER_WRAP_BURST_EN
        input  req_wrap,
`endif
        input  req_valid, req_write, req_addr, req_len, req_strb,
        input  wd_data, wd_valid, rd_ready,
        output req_ready, wd_ready, rd_data, rd_valid, rd_last,
        output resp_valid, resp_err, busy,
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        input  ARREADY_M,
        input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output RREADY_M,
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M
    );

    modport slave (
`ifdef AXI_MASTER_WRAP_BURST_EN
        output req_wrap,
`endif
        output req_valid, req_write, req_addr, req_len, req_strb,
        output wd_data, wd_valid, rd_ready,
        input  req_ready, wd_ready, rd_data, rd_valid, rd_last,
        input  resp_valid, resp_err, busy,
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        output ARREADY_M,
        output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        input  RREADY_M,
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M
    );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 burst master: one request at a time becomes an INCR (or WRAP) burst.
// Optional WRAP bursts are enabled by defining AXI_MASTER_WRAP_BURST_EN.
module axi_burst_master #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 32,
    parameter int              ID_W    = 4,
    parameter logic [ID_W-1:0] MST_ID  = '0,
    parameter int              MAX_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_burst_master_if.master    bus,
    output logic [2:0]            dbg_state
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SIZE   = $clog2(STRB_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0, AR = 3'd1, R = 3'd2, AW = 3'd3, W = 3'd4, B = 3'd5, RESP = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [STRB_W-1:0] strb_q;
    logic              err_q;
    logic [4:0]        beat_q;
    logic [1:0]        burst_c;

    logic              accept, reject, r_hs, w_hs, last_beat;
    logic [ADDR_W-1:0] aligned, base;
    logic [12:0]       bytes;
    logic [13:0]       end_off;
    logic              len_bad;
    logic              unused_ids;

    assign unused_ids = ^{bus.RID_M, bus.BID_M};
    assign dbg_state  = state_q;
    assign accept     = bus.req_valid && (state_q == IDLE);
    assign r_hs       = (state_q == R) && bus.RVALID_M && bus.rd_ready;
    assign w_hs       = (state_q == W) && bus.wd_valid && bus.WREADY_M;
    assign last_beat  = (beat_q == {1'b0, len_q});

`ifdef AXI_MASTER_WRAP_BURST_EN
    logic wrap_q;
    assign burst_c = wrap_q ? 2'b10 : 2'b01;
`else
    assign burst_c = 2'b01;
`endif

    // Legality of the incoming request: length limit and 4KB page crossing.
    always_comb begin
        aligned = bus.req_addr & ~ADDR_W'(STRB_W - 1);
        bytes   = (13'(bus.req_len) + 13'd1) << SIZE;
        base    = aligned;
        len_bad = ({1'b0, bus.req_len} > 5'(MAX_LEN - 1));
`ifdef AXI_MASTER_WRAP_BURST_EN
        if (bus.req_wrap) begin
            base    = aligned & ~ADDR_W'(bytes - 13'd1);
            len_bad = len_bad || !((bus.req_len == 4'd1) || (bus.req_len == 4'd3) ||
                                   (bus.req_len == 4'd7) || (bus.req_len == 4'd15));
        end
`endif
        end_off = 14'(base[11:0]) + 14'(bytes);
        reject  = len_bad || (end_off > 14'd4096);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
`ifdef AXI_MASTER_WRAP_BURST_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= aligned;
                len_q  <= bus.req_len;
                strb_q <= bus.req_strb;
                err_q  <= reject;
                beat_q <= '0;
`ifdef AXI_MASTER_WRAP_BURST_EN
                wrap_q <= bus.req_wrap;
`endif
            end else begin
                // Read beat counter saturates so a missing RLAST never aliases to beat 0.
                if (r_hs) begin
                    beat_q <= (beat_q == 5'h1f) ? beat_q : beat_q + 5'd1;
                    err_q  <= err_q || (bus.RRESP_M != 2'b00) || (bus.RLAST_M != last_beat);
                end
                if (w_hs) beat_q <= beat_q + 5'd1;
                if ((state_q == B) && bus.BVALID_M) err_q <= err_q || (bus.BRESP_M != 2'b00);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.wd_ready   = 1'b0;
        bus.rd_data    = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_last    = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.ARID_M     = '0;
        bus.ARADDR_M   = '0;
        bus.ARLEN_M    = '0;
        bus.ARSIZE_M   = '0;
        bus.ARBURST_M  = '0;
        bus.ARVALID_M  = 1'b0;
        bus.RREADY_M   = 1'b0;
        bus.AWID_M     = '0;
        bus.AWADDR_M   = '0;
        bus.AWLEN_M    = '0;
        bus.AWSIZE_M   = '0;
        bus.AWBURST_M  = '0;
        bus.AWVALID_M  = 1'b0;
        bus.WDATA_M    = '0;
        bus.WSTRB_M    = '0;
        bus.WLAST_M    = 1'b0;
        bus.WVALID_M   = 1'b0;
        bus.BREADY_M   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) state_d = reject ? RESP : (bus.req_write ? AW : AR);
            end
            AR: begin
                bus.ARID_M    = MST_ID;
                bus.ARADDR_M  = addr_q;
                bus.ARLEN_M   = len_q;
                bus.ARSIZE_M  = 3'(SIZE);
                bus.ARBURST_M = burst_c;
                bus.ARVALID_M = 1'b1;
                if (bus.ARREADY_M) state_d = R;
            end
            R: begin
                bus.RREADY_M = bus.rd_ready;
                bus.rd_valid = bus.RVALID_M;
                bus.rd_data  = bus.RDATA_M;
                bus.rd_last  = bus.RLAST_M;
                if (r_hs && bus.RLAST_M) state_d = RESP;
            end
            AW: begin
                bus.AWID_M    = MST_ID;
                bus.AWADDR_M  = addr_q;
                bus.AWLEN_M   = len_q;
                bus.AWSIZE_M  = 3'(SIZE);
                bus.AWBURST_M = burst_c;
                bus.AWVALID_M = 1'b1;
                if (bus.AWREADY_M) state_d = W;
            end
            W: begin
                bus.WVALID_M = bus.wd_valid;
                bus.wd_ready = bus.WREADY_M;
                bus.WDATA_M  = bus.wd_data;
                bus.WSTRB_M  = strb_q;
                bus.WLAST_M  = last_beat;
                if (w_hs && last_beat) state_d = B;
            end
            B: begin
                bus.BREADY_M = 1'b1;
                if (bus.BVALID_M) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
